// File: rtl/result_reader.sv
// Drains a block of result-SRAM words into a valid/ready beat stream.
// The address register feeds a one-cycle SRAM; returned words land in an output register backed by a 2-entry FIFO.
`ifndef SRAM_ADDR_RANGE
`define SRAM_ADDR_RANGE 11:0
`endif
`ifndef SRAM_DATA_RANGE
`define SRAM_DATA_RANGE 31:0
`endif

module result_reader #(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    drain_valid,
  output logic                    drain_ready,
  input  logic [`SRAM_ADDR_RANGE] drain_base_address,
  input  logic [CNT_W-1:0]        drain_count,
  output logic [`SRAM_ADDR_RANGE] dut__tb__sram_result_read_address,
  input  logic [`SRAM_DATA_RANGE] tb__dut__sram_result_read_data,
  output logic                    dut__tb__sram_result_write_enable,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [`SRAM_DATA_RANGE] out_data,
  output logic [CNT_W-1:0]        out_index,
  output logic                    out_last,
  output logic                    drain_done
);

  typedef logic [`SRAM_ADDR_RANGE] addr_t;
  typedef logic [`SRAM_DATA_RANGE] data_t;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

  localparam int AW = $bits(addr_t);
  localparam int DW = $bits(data_t);
  localparam addr_t ADDR_ZERO = {AW{1'b0}};
  localparam addr_t ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam data_t DATA_ZERO = {DW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  addr_t            addr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] rem_r;
  logic             drain_ready_r;
  logic             drain_done_r;

  logic             rd_v1_r;
  logic             rd_v2_r;
  data_t            fifo_mem_r [2];
  logic             fifo_rd_r;
  logic             fifo_wr_r;
  logic [1:0]       fifo_cnt_r;
  logic [CNT_W-1:0] load_idx_r;

  data_t            out_data_r;
  logic [CNT_W-1:0] out_index_r;
  logic             out_valid_r;
  logic             out_last_r;

  logic             accept_s;
  logic             start_read_s;
  logic             pop_s;
  logic             fill_s;
  logic             from_fifo_s;
  logic             push_s;
  logic [2:0]       pending_s;
  logic             issue_s;

  // Handshakes, read credit and steering of returned data for this cycle
  always_comb begin
    accept_s     = drain_valid & drain_ready_r;
    start_read_s = accept_s & (drain_count != CNT_ZERO);
    pop_s        = out_valid_r & out_ready;
    fill_s       = (~out_valid_r | out_ready) & ((fifo_cnt_r != 2'd0) | rd_v2_r);
    from_fifo_s  = fill_s & (fifo_cnt_r != 2'd0);
    // Returned word bypasses the FIFO only when it is empty and the output register takes it
    push_s       = rd_v2_r & ~(fill_s & (fifo_cnt_r == 2'd0));
    // FIFO occupancy plus reads in flight once this edge's move into the output register is done
    pending_s    = {1'b0, fifo_cnt_r} + {2'b00, rd_v1_r} + {2'b00, rd_v2_r} - {2'b00, fill_s};
    issue_s      = (state_r == READ) & (rem_r != CNT_ZERO) & (pending_s < 3'd2);
  end

  // Drain control FSM with read address generation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      addr_r        <= ADDR_ZERO;
      count_r       <= CNT_ZERO;
      rem_r         <= CNT_ZERO;
      drain_ready_r <= 1'b1;
      drain_done_r  <= 1'b0;
    end else begin
      drain_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            count_r       <= drain_count;
            drain_ready_r <= 1'b0;
            if (drain_count == CNT_ZERO) begin
              state_r      <= DONE;
              drain_done_r <= 1'b1;
            end else begin
              // The first read goes out on the accept edge itself
              state_r <= READ;
              addr_r  <= drain_base_address;
              rem_r   <= drain_count - CNT_ONE;
            end
          end
        end
        READ: begin
          if (rem_r == CNT_ZERO) begin
            state_r <= FLUSH;
          end else if (issue_s) begin
            addr_r <= addr_r + ADDR_ONE;
            rem_r  <= rem_r - CNT_ONE;
            if (rem_r == CNT_ONE) begin
              state_r <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (pop_s && out_last_r) begin
            state_r      <= DONE;
            drain_done_r <= 1'b1;
          end
        end
        DONE: begin
          state_r       <= IDLE;
          drain_ready_r <= 1'b1;
        end
        default: begin
          state_r       <= IDLE;
          drain_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Read return pipeline, two-entry FIFO and output beat register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1_r       <= 1'b0;
      rd_v2_r       <= 1'b0;
      fifo_mem_r[0] <= DATA_ZERO;
      fifo_mem_r[1] <= DATA_ZERO;
      fifo_rd_r     <= 1'b0;
      fifo_wr_r     <= 1'b0;
      fifo_cnt_r    <= 2'd0;
      load_idx_r    <= CNT_ZERO;
      out_data_r    <= DATA_ZERO;
      out_index_r   <= CNT_ZERO;
      out_valid_r   <= 1'b0;
      out_last_r    <= 1'b0;
    end else begin
      rd_v1_r <= start_read_s | issue_s;
      rd_v2_r <= rd_v1_r;
      if (push_s) begin
        fifo_mem_r[fifo_wr_r] <= tb__dut__sram_result_read_data;
        fifo_wr_r             <= ~fifo_wr_r;
      end
      if (from_fifo_s) begin
        fifo_rd_r <= ~fifo_rd_r;
      end
      fifo_cnt_r <= fifo_cnt_r + {1'b0, push_s} - {1'b0, from_fifo_s};
      if (accept_s) begin
        load_idx_r <= CNT_ZERO;
      end else if (fill_s) begin
        load_idx_r <= load_idx_r + CNT_ONE;
      end
      if (fill_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= from_fifo_s ? fifo_mem_r[fifo_rd_r] : tb__dut__sram_result_read_data;
        out_index_r <= load_idx_r;
        out_last_r  <= (load_idx_r == count_r - CNT_ONE);
      end else if (pop_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  assign drain_ready                       = drain_ready_r;
  assign drain_done                        = drain_done_r;
  assign dut__tb__sram_result_read_address = addr_r;
  assign dut__tb__sram_result_write_enable = 1'b0;
  assign out_valid                         = out_valid_r;
  assign out_data                          = out_data_r;
  assign out_index                         = out_index_r;
  assign out_last                          = out_last_r;

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: table-driven and random drains scored against a queue model of the SRAM walk.
`ifndef SRAM_ADDR_RANGE
`define SRAM_ADDR_RANGE 11:0
`endif
`ifndef SRAM_DATA_RANGE
`define SRAM_DATA_RANGE 31:0
`endif

module tb_result_reader;

  typedef struct {
    int base;
    int cnt;
    int mode;       // 0: ready held 1, 1: ready 1,0,0 repeating, 2: random ready
    int exp_first;  // expected cycle of first out_valid after accept, -1 if not checked
  } vec_t;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    drain_valid;
  logic                    drain_ready;
  logic [`SRAM_ADDR_RANGE] drain_base_address;
  logic [15:0]             drain_count;
  logic [`SRAM_ADDR_RANGE] rd_addr;
  logic [`SRAM_DATA_RANGE] rdata;
  logic                    we;
  logic                    out_valid;
  logic                    out_ready;
  logic [`SRAM_DATA_RANGE] out_data;
  logic [15:0]             out_index;
  logic                    out_last;
  logic                    drain_done;

  logic [31:0] mem [4096];
  int total = 0;
  int bad = 0;

  result_reader #(.CNT_W(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .drain_valid(drain_valid),
    .drain_ready(drain_ready),
    .drain_base_address(drain_base_address),
    .drain_count(drain_count),
    .dut__tb__sram_result_read_address(rd_addr),
    .tb__dut__sram_result_read_data(rdata),
    .dut__tb__sram_result_write_enable(we),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_index(out_index),
    .out_last(out_last),
    .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  // One-cycle SRAM: data for the presented address appears in the following cycle
  always @(posedge clk) rdata <= mem[rd_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 64'(drain_ready), 64'd1);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
    check({tag, "_index"}, 64'(out_index), 64'd0);
    check({tag, "_data"}, 64'(out_data), 64'd0);
    check({tag, "_done"}, 64'(drain_done), 64'd0);
    check({tag, "_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_we"}, 64'(we), 64'd0);
  endtask

  // Runs one drain and scores it; with hold set, drain_valid stays high carrying the next request
  task automatic do_drain(input int base, input int cnt, input int mode, input int exp_first,
                          input bit hold, input int hbase, input int hcnt);
    logic [31:0] got_d[$];
    int got_i[$];
    int got_l[$];
    int addr_q[$];
    int first_c, done_c, last_c, max_out, unstable, ready_busy, moved, issued, outst;
    bit stall_prev, r, finished;
    logic [31:0] pd;
    logic [15:0] pi;
    logic pl;
    logic [11:0] addr_before;
    first_c = -1; done_c = -1; last_c = -1; max_out = 0; unstable = 0;
    ready_busy = 0; moved = 0; stall_prev = 1'b0; finished = 1'b0;
    pd = 32'd0; pi = 16'd0; pl = 1'b0; r = 1'b0;
    @(negedge clk);
    check("ready_idle", 64'(drain_ready), 64'd1);
    check("done_pulse_width", 64'(drain_done), 64'd0);
    addr_before = rd_addr;
    drain_valid = 1'b1;
    drain_base_address = 12'(base);
    drain_count = 16'(cnt);
    for (int c = 1; c <= 300 && !finished; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) begin
          drain_base_address = 12'(hbase);
          drain_count = 16'(hcnt);
        end else begin
          drain_valid = 1'b0;
        end
      end
      if (stall_prev && (out_valid !== 1'b1 || out_data !== pd || out_index !== pi || out_last !== pl))
        unstable++;
      if (drain_ready !== 1'b0) ready_busy++;
      if (cnt == 0 && rd_addr !== addr_before) moved++;
      if (c == 1 || rd_addr != 12'(addr_q[$])) addr_q.push_back(int'(rd_addr));
      if (cnt > 0) begin
        issued = ((int'(rd_addr) - base) & 32'hFFF) + 1;
        outst = issued - got_d.size() - (out_valid === 1'b1 ? 1 : 0);
        if (outst > max_out) max_out = outst;
      end
      if (out_valid === 1'b1 && first_c < 0) first_c = c;
      if (drain_done === 1'b1) begin
        done_c = c;
        finished = 1'b1;
      end else begin
        case (mode)
          0: r = 1'b1;
          1: r = ((c - 1) % 3 == 0);
          default: r = 1'($urandom_range(0, 1));
        endcase
        out_ready = r;
        if (out_valid === 1'b1 && r) begin
          got_d.push_back(out_data);
          got_i.push_back(int'(out_index));
          got_l.push_back(int'(out_last));
          last_c = c;
        end
        stall_prev = (out_valid === 1'b1) && !r;
        pd = out_data; pi = out_index; pl = out_last;
      end
    end
    check("done_seen", 64'(finished), 64'd1);
    check("beat_count", 64'(got_d.size()), 64'(cnt));
    for (int i = 0; i < got_d.size() && i < cnt; i++) begin
      check("beat_data", 64'(got_d[i]), 64'(mem[(base + i) & 32'hFFF]));
      check("beat_index", 64'(got_i[i]), 64'(i));
      check("beat_last", 64'(got_l[i]), 64'(i == cnt - 1));
    end
    check("stall_stable", 64'(unstable), 64'd0);
    check("busy_not_ready", 64'(ready_busy), 64'd0);
    if (cnt == 0) begin
      check("addr_unchanged", 64'(moved), 64'd0);
      check("done_latency", 64'(done_c), 64'd1);
    end else begin
      check("addr_seq_len", 64'(addr_q.size()), 64'(cnt));
      for (int i = 0; i < addr_q.size() && i < cnt; i++)
        check("addr_seq", 64'(addr_q[i]), 64'((base + i) & 32'hFFF));
      check("max_outstanding_le2", 64'(max_out <= 2), 64'd1);
      check("done_after_last", 64'(done_c), 64'(last_c + 1));
      if (exp_first >= 0) begin
        check("first_latency", 64'(first_c), 64'(exp_first));
        check("done_latency", 64'(done_c), 64'(cnt + 3));
      end
    end
  endtask

  initial begin
    vec_t vecs[6];
    int stale;
    int rb, rc, rm;
    vecs[0] = '{base: 32'h010, cnt: 4, mode: 0, exp_first: 3};
    vecs[1] = '{base: 32'h020, cnt: 8, mode: 1, exp_first: -1};
    vecs[2] = '{base: 32'hFFE, cnt: 3, mode: 0, exp_first: 3};
    vecs[3] = '{base: 32'h100, cnt: 1, mode: 0, exp_first: 3};
    vecs[4] = '{base: 32'h200, cnt: 5, mode: 2, exp_first: -1};
    vecs[5] = '{base: 32'h300, cnt: 2, mode: 1, exp_first: -1};
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[12'h010] = 32'hAAAA_000A;
    mem[12'h011] = 32'hBBBB_000B;
    mem[12'h012] = 32'hCCCC_000C;
    mem[12'h013] = 32'hDDDD_000D;

    reset_n = 1'b0;
    drain_valid = 1'b0;
    drain_base_address = 12'd0;
    drain_count = 16'd0;
    out_ready = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 6; v++)
      do_drain(vecs[v].base, vecs[v].cnt, vecs[v].mode, vecs[v].exp_first, 1'b0, 0, 0);

    // Zero-length drain
    do_drain(32'h030, 0, 0, -1, 1'b0, 0, 0);

    // Request held during a drain with another base: ignored until idle, then accepted
    do_drain(32'h040, 4, 0, 3, 1'b1, 32'h080, 3);
    do_drain(32'h080, 3, 0, 3, 1'b0, 0, 0);

    // Reset mid-drain after the second of six beats
    @(negedge clk);
    drain_valid = 1'b1;
    drain_base_address = 12'h600;
    drain_count = 16'd6;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drain_valid = 1'b0;
      if (k >= 3) begin
        check("pre_reset_data", 64'(out_data), 64'(mem[12'h600 + k - 3]));
        check("pre_reset_index", 64'(out_index), 64'(k - 3));
      end
    end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || drain_done !== 1'b0) stale++;
    end
    check("no_stale_beat", 64'(stale), 64'd0);
    do_drain(32'h700, 2, 0, 3, 1'b0, 0, 0);

    for (int n = 0; n < 6; n++) begin
      rb = $urandom_range(0, 4095);
      rc = $urandom_range(1, 12);
      rm = $urandom_range(0, 2);
      do_drain(rb, rc, rm, (rm == 0) ? 3 : -1, 1'b0, 0, 0);
    end

    @(negedge clk);
    check("final_we", 64'(we), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
